// File: rtl/alu_serial_sequencer_pkg.sv
// Shared encodings for the bit-serial ALU sequencer.
// Op codes follow the slice's {binv, sel[1:0]} layout.
package alu_serial_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic logic ovf_op(
    input logic [2:0] op
  );
    return op[1:0] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_serial_sequencer_if.sv
// Request/flag bus plus one-bit slice bus.
// master is the issuer and slice; slave is the sequencer.
interface alu_serial_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;
  logic             s_a;
  logic             s_b;
  logic             s_cin;
  logic             s_less;
  logic [2:0]       s_op;
  logic             s_result;
  logic             s_cout;
  logic             s_set;

  modport master (
    output start, op, a, b,
    input  busy, done, result,
    input  zero, cout, overflow,
    input  s_a, s_b, s_cin,
    input  s_less, s_op,
    output s_result, s_cout, s_set
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result,
    output zero, cout, overflow,
    output s_a, s_b, s_cin,
    output s_less, s_op,
    input  s_result, s_cout, s_set
  );
endinterface

// File: rtl/alu_serial_sequencer.sv
// Steps one external ALU slice LSB-first over WIDTH bits,
// threading carry and fixing up SLT into result[0].
module alu_serial_sequencer
  import alu_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_serial_sequencer_if.slave bus
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;
  logic             accept;
  logic             run;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    run      = state == RUN;
    accept   = (state == IDLE) && bus.start;
    last     = run && (idx == LAST);
    bus.busy = state != IDLE;
    bus.done = state == DONE;
    bus.s_a    = run & a_q[idx];
    bus.s_b    = run & b_q[idx];
    bus.s_cin  = run & carry;
    bus.s_less = 1'b0;
    bus.s_op   = op_q;
  end

  // SLT: MSB sum bit becomes the whole answer, sampled MSB stays 0
  always_comb begin
    res_nxt      = res_q;
    res_nxt[idx] = bus.s_result;
    if (last && op_q == OP_SLT)
      res_nxt[0] = bus.s_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.a;
      b_q    <= bus.b;
      op_q   <= bus.op;
      carry  <= bus.op[2];
      idx    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (run) begin
      res_q <= res_nxt;
      carry <= bus.s_cout;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) begin
        zero_q <= res_nxt == '0;
        cout_q <= op_q[1] & bus.s_cout;
        ovf_q  <= ovf_op(op_q)
                & (carry ^ bus.s_cout);
      end
    end
  end

  assign bus.result   = res_q;
  assign bus.zero     = zero_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a
// behavioural one-bit slice on the s_* bus.
module tb_alu_serial_sequencer;
  import alu_serial_sequencer_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic bb;

  always #5 clk = ~clk;

  alu_serial_sequencer_if #(.WIDTH(W)) bus();

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_comb begin
    bb = bus.s_b ^ bus.s_op[2];
    bus.s_set  = bus.s_a ^ bb ^ bus.s_cin;
    bus.s_cout = (bus.s_a & bb)
               | (bus.s_a & bus.s_cin)
               | (bb & bus.s_cin);
    case (bus.s_op[1:0])
      2'b00:   bus.s_result = bus.s_a & bb;
      2'b01:   bus.s_result = bus.s_a | bb;
      2'b10:   bus.s_result = bus.s_set;
      default: bus.s_result = bus.s_less;
    endcase
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, got, exp);
    end
  endtask

  task automatic do_op(
    input string      tag,
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] er,
    input logic       ez,
    input logic       ec,
    input logic       ev
  );
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    lat = 1;
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = a ^ b;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
    end
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_zero"}, bus.zero, ez);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"}, bus.overflow, ev);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, bus.done, 0);
  endtask

  initial begin
    int ndone;
    logic [7:0] got_r;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flags",
        {bus.zero, bus.cout, bus.overflow}, 0);
    chk("rst_slice",
        {bus.s_a, bus.s_b, bus.s_cin, bus.s_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_5_3", OP_ADD, 8'h05, 8'h03,
          8'h08, 0, 0, 0);
    do_op("sub_3_5", OP_SUB, 8'h03, 8'h05,
          8'hFE, 0, 0, 0);
    do_op("sub_5_5", OP_SUB, 8'h05, 8'h05,
          8'h00, 1, 1, 0);
    do_op("slt_m3_2", OP_SLT, 8'hFD, 8'h02,
          8'h01, 0, 1, 0);
    do_op("slt_2_m3", OP_SLT, 8'h02, 8'hFD,
          8'h00, 1, 0, 0);
    do_op("add_ovf", OP_ADD, 8'h7F, 8'h01,
          8'h80, 0, 0, 1);
    do_op("add_wrap", OP_ADD, 8'hFF, 8'h01,
          8'h00, 1, 1, 0);
    do_op("sub_ovf", OP_SUB, 8'h80, 8'h01,
          8'h7F, 0, 1, 1);
    do_op("and", OP_AND, 8'hF0, 8'h3C,
          8'h30, 0, 0, 0);
    do_op("or", OP_OR, 8'hF0, 8'h0C,
          8'hFC, 0, 0, 0);
    do_op("op011", 3'b011, 8'hFD, 8'h02,
          8'h00, 1, 0, 0);

    chk("idle_slice",
        {bus.s_a, bus.s_b, bus.s_cin}, 0);
    chk("idle_s_op", bus.s_op, 3'b011);
    chk("idle_busy", bus.busy, 0);
    chk("held_result", bus.result, 8'h00);

    // start held high through RUN and DONE, operands churning
    @(negedge clk);
    bus.op    = OP_ADD;
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    bus.start = 1'b1;
    ndone = 0;
    got_r = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        ndone++;
        got_r = bus.result;
        chk("b2b_s_op", bus.s_op, OP_ADD);
      end
      if (i < 9) begin
        bus.start = 1'b1;
        bus.a     = 8'(i * 17 + 1);
        bus.b     = 8'(i + 9);
        bus.op    = OP_SUB;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("b2b_ndone", ndone, 1);
    chk("b2b_result", got_r, 8'h08);
    chk("b2b_busy", bus.busy, 0);

    // abort with reset at idx 4
    @(negedge clk);
    bus.op    = OP_ADD;
    bus.a     = 8'h11;
    bus.b     = 8'h22;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_done", bus.done, 0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", OP_ADD, 8'h7F, 8'h01,
          8'h80, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
